// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle RV32M divider.
package div_pkg;

  localparam int DIV_XLEN = 32;
  // Cycles from an accepted start to the valid pulse on the normal path.
  localparam int DIV_LAT  = DIV_XLEN + 2;

  // Encodings match funct3[1:0] of DIV/DIVU/REM/REMU.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

  // DIV and REM treat operands as two's complement.
  function automatic logic op_signed(input div_op_t op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic            quo_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The shifted remainder keeps rem's MSB, so divisors above 2^(XLEN-1)
  // still compare correctly; bit XLEN of the difference is the borrow.
  always_comb begin
    shifted  = {rem, quo_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle shift-subtract divider for DIV/DIVU/REM/REMU.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start
//   S_CALC | one quotient bit per cycle, XLEN cycles
//   S_FIX  | sign-correct and register the result (special cases pass
//          | through unchanged)
//   S_DONE | valid pulse; start here is accepted like in S_IDLE
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_t      state;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic            res_is_rem;
  logic            q_neg;
  logic            r_neg;
  logic            dz_pend;

  div_op_t         op_in;
  logic            in_signed;
  logic            in_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            is_zero;
  logic            is_ovf;
  logic [XLEN-1:0] spec_val;
  logic [XLEN-1:0] rem_next;
  logic            q_bit;
  logic [XLEN-1:0] res_raw;
  logic            res_neg;
  logic [XLEN-1:0] res_fixed;

  // Operand conditioning at acceptance: magnitudes, signs and the two
  // results that bypass the iteration (divide by zero, signed overflow).
  always_comb begin
    op_in     = div_op_t'(op);
    in_signed = op_signed(op_in);
    in_rem    = op_rem(op_in);
    a_neg     = in_signed & dividend[XLEN-1];
    b_neg     = in_signed & divisor[XLEN-1];
    a_abs     = a_neg ? -dividend : dividend;
    b_abs     = b_neg ? -divisor  : divisor;
    is_zero   = (divisor == '0);
    is_ovf    = in_signed
              & (dividend == {1'b1, {(XLEN-1){1'b0}}})
              & (divisor == '1);
    if (is_zero)
      spec_val = in_rem ? dividend : '1;
    else
      spec_val = in_rem ? '0 : dividend;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo_msb  (quo[XLEN-1]),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Result selection with a single shared negator.
  always_comb begin
    res_raw   = res_is_rem ? rem : quo;
    res_neg   = res_is_rem ? r_neg : q_neg;
    res_fixed = res_neg ? -res_raw : res_raw;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      div_zero   <= 1'b0;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      res_is_rem <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz_pend    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            res_is_rem <= in_rem;
            dz_pend    <= is_zero;
            if (is_zero || is_ovf) begin
              // Preload both halves so FIX emits spec_val with no negation.
              quo   <= spec_val;
              rem   <= spec_val;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              cnt   <= '0;
              state <= S_FIX;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              dvsr  <= b_abs;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= CNT_W'(XLEN-1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo <= {quo[XLEN-2:0], q_bit};
          rem <= rem_next;
          if (cnt == '0)
            state <= S_FIX;
          else
            cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          result   <= res_fixed;
          div_zero <= dz_pend;
          busy     <= 1'b0;
          valid    <= 1'b1;
          state    <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .valid    (valid),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic edz,
                        input int elat);
    int  n;
    int  nb;
    bit  got;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (valid) got = 1'b1;
      else if (busy) nb++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no valid want valid within 60 cycles", nm);
    end else begin
      chk({nm, "_lat"},  32'(n),  32'(elat));
      chk({nm, "_busy"}, 32'(nb), 32'(elat - 1));
      chk({nm, "_res"},  result,  er);
      chk({nm, "_dz"},   32'(div_zero), 32'(edz));
      @(negedge clk);
      chk({nm, "_vpulse"}, 32'(valid), 32'd0);
      chk({nm, "_hold"},   result, er);
    end
  endtask

  initial begin
    int nv;
    int vcyc[3];
    logic [31:0] vres[3];
    bit got;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 34};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 34};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 34};
    vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 2};
    vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, 2};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 2};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 2};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0, 34};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0, 34};
    vecs[11] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 34};
    vecs[12] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0, 34};
    vecs[13] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 34};
    vecs[14] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 34};
    vecs[15] = '{2'b11, 32'd3,          32'd5,          32'd3,          1'b0, 34};
    vecs[16] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 34};
    vecs[17] = '{2'b10, 32'd0,          32'd0,          32'd0,          1'b1, 2};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_valid", 32'(valid),    32'd0);
    chk("rst_res",   result,        32'd0);
    chk("rst_dz",    32'(div_zero), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].dz, vecs[i].lat);

    // Streaming: start held high; operands change right after the first
    // acceptance and must only affect the op accepted in the DONE cycle.
    @(negedge clk);
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    nv = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin dividend = 32'd1000; divisor = 32'd10; end
      if (valid) begin
        if (nv < 3) begin vcyc[nv] = c; vres[nv] = result; end
        nv++;
      end
    end
    start = 1'b0;
    chk("stream_count", 32'(nv), 32'd2);
    if (nv >= 2) begin
      chk("stream_first_lat", 32'(vcyc[0]), 32'd34);
      chk("stream_res0",      vres[0],      32'd14);
      chk("stream_res1",      vres[1],      32'd100);
      chk("stream_spacing",   32'(vcyc[1] - vcyc[0]), 32'd34);
    end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (valid) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL stream_drain_timeout: got no valid want third result");
    end else begin
      chk("stream_res2", result, 32'd100);
    end

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_valid", 32'(valid),    32'd0);
    chk("mid_rst_res",   result,        32'd0);
    chk("mid_rst_dz",    32'(div_zero), 32'd0);
    rst_n = 1'b1;
    run_op("after_rst", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
